stopwatch_display: RTL and testbench
====================================

STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 SHALL have parameter BLANK_LZ, default 1, meaning blank the hour-tens digit when it is 0.
REQ-002 SHALL have parameter BLINK_DIV, default 250, meaning blink half-period in clk_1khz cycles.
REQ-003 SHALL have port clk_1khz, input, 1 bit: single scan clock; the block has one clock and all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports centisec, sec, min, hour, each input, 8 bits: binary time values from the stopwatch controller.
REQ-006 SHALL have port blink_en, input, 1 bit: flash the whole display.
REQ-007 SHALL have port an, output, 8 bits, registered: digit enables, active-low; bit 0 is the rightmost digit.
REQ-008 SHALL have port seg, output, 8 bits, registered: segments, active-low; bits [6:0] are g..a and bit 7 is dp.

Function
REQ-009 Digit map SHALL be: 0 centisec ones; 1 centisec tens; 2 sec ones; 3 sec tens; 4 min ones; 5 min tens; 6 hour ones; 7 hour tens.
REQ-010 Scan SHALL use a 3-bit digit index plus a 1-bit phase; each slot lasts 2 cycles, and a frame is 16 cycles.
REQ-011 Phase 0 of each slot SHALL be the ghost guard: an = 8'hFF.
REQ-012 Phase 1 SHALL drive an with only the bit for the current index low.
REQ-013 The index SHALL increment after phase 1 and wrap from 7 to 0.
REQ-014 At index 0 phase 0, all four inputs SHALL be captured into snapshot registers.
REQ-015 All digits of a frame SHALL be decoded from the snapshot only, so mid-frame input changes never tear the display.
REQ-016 Each snapshot byte SHALL be split into tens and ones (0-99).
REQ-017 A snapshot value greater than 99 SHALL saturate to 99 (display "99").
REQ-018 Segment patterns SHALL follow the standard hex-free 0-9 table; for example, 0 gives seg[6:0] = 7'b1000000 and 8 gives 7'b0000000.
REQ-019 dp (seg[7]) SHALL be 0 (lit) on digits 2, 4 and 6, and 1 elsewhere.
REQ-020 With BLANK_LZ = 1 and hour tens = 0, digit 7 SHALL output seg = 8'hFF while its anode is still scanned.
REQ-021 The blink counter SHALL count 0..BLINK_DIV-1; at terminal count it SHALL toggle blink_off and return to 0.
REQ-022 While blink_en = 1 and blink_off = 1, an SHALL be 8'hFF regardless of phase; the scan SHALL continue.
REQ-023 Deasserting blink_en SHALL clear the blink counter and blink_off on the next edge; the display SHALL be visible from the following cycle.
REQ-024 seg and an SHALL both be registered from the same index/phase, so they change on the same edge.
REQ-025 The first lit slot after capture (digit 0, phase 1) SHALL appear 1 cycle after the capture edge.

Reset
REQ-026 While rst_n = 0, outputs SHALL be an = 8'hFF and seg = 8'hFF, asynchronously.
REQ-027 While rst_n = 0, index, phase, blink counter and blink_off SHALL be 0, and all snapshots SHALL be 0.
REQ-028 On the first edge after rst_n rises, the block SHALL be at index 0 phase 0, so capture occurs on that edge.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; no partial digit SHALL remain lit.

Structure
REQ-030 A shared package SHALL hold the digit-count constant (8), the guard/lit phase encodings, the 10-entry active-low segment table, and the dp digit mask 8'b0101_0100.
REQ-031 One sub-module, bin2bcd99, SHALL be instantiated once on the mux-selected snapshot byte.
REQ-032 bin2bcd99 SHALL be combinational: 8-bit in, saturate at 99, 4-bit tens and 4-bit ones out.
REQ-033 The scan, snapshot, blink and output registers SHALL reside in stopwatch_display.

Verification
REQ-034 Reset release with centisec=7, sec=42, min=5, hour=3 -> over 16 cycles, lit digits 7..0 read blank,3,0,5,4,2,0,7, with dp on 2/4/6 and every phase-0 cycle an = FF.
REQ-035 sec changes 41 -> 42 at frame cycle 5 -> current frame still shows 41; the next frame shows 42.
REQ-036 hour=200, min=150 -> digits show 99 and 99 (saturation); with BLANK_LZ=0 and hour=4, digit 7 shows 0.
REQ-037 blink_en=1, BLINK_DIV=4 -> an = FF for 4 cycles, then scanning for 4, repeating; dropping blink_en -> scanning resumes within 2 cycles.
REQ-038 rst_n pulsed low during the digit 4 lit phase -> an and seg go to FF without a clock; after release, capture occurs on the first edge.
REQ-039 Over a 1000-cycle run, exactly one an bit is low in every phase-1 cycle and none is low in any phase-0 cycle.

Source files
------------

// File: rtl/stopwatch_display_pkg.sv
// Shared constants for the stopwatch 8-digit multiplexed display:
// digit count, scan phase encoding, segment table and decimal-point mask.
package stopwatch_display_pkg;

    localparam int NUM_DIGITS = 8;

    typedef enum logic {
        PH_GUARD = 1'b0,
        PH_LIT   = 1'b1
    } phase_t;

    // Active-low g..a patterns, entry n at index n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [7:0] DP_MASK = 8'b0101_0100;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        seg_of = 7'h7F;
        if (d <= 4'd9) begin
            seg_of = SEG_TABLE[d];
        end
    endfunction

endpackage

// File: rtl/stopwatch_display_bin2bcd99.sv
// Combinational 0-99 binary to two BCD digits; inputs above 99 read as 99.
module bin2bcd99
    import stopwatch_display_pkg::*;
(
    input  logic [7:0] i_bin,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones
);

    logic [7:0] w_sat;
    logic [3:0] w_tens;
    logic [7:0] w_rem;

    assign w_sat = (i_bin > 8'd99) ? 8'd99 : i_bin;

    always_comb begin
        w_tens = 4'd0;
        for (int k = 1; k < 10; k++) begin
            if (w_sat >= 8'(k * 10)) begin
                w_tens = 4'(k);
            end
        end
        w_rem = w_sat - ({4'd0, w_tens} * 8'd10);
    end

    assign o_tens = w_tens;
    assign o_ones = w_rem[3:0];

endmodule

// File: rtl/stopwatch_display.sv
// Eight-digit multiplexed LED driver for a stopwatch: snapshots the time once
// per frame, scans digits with a dark guard phase, and optionally blinks.
module stopwatch_display
    import stopwatch_display_pkg::*;
#(
    parameter int BLANK_LZ  = 1,
    parameter int BLINK_DIV = 250
) (
    input  logic       clk_1khz,
    input  logic       rst_n,
    input  logic [7:0] centisec,
    input  logic [7:0] sec,
    input  logic [7:0] min,
    input  logic [7:0] hour,
    input  logic       blink_en,
    output logic [7:0] an,
    output logic [7:0] seg
);

    localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [2:0]     r_idx;
    phase_t         r_phase;
    logic [7:0]     r_snap_cs;
    logic [7:0]     r_snap_sec;
    logic [7:0]     r_snap_min;
    logic [7:0]     r_snap_hour;
    logic [BCW-1:0] r_blink_cnt;
    logic           r_blink_off;
    logic [7:0]     r_an;
    logic [7:0]     r_seg;

    logic [7:0] w_sel_byte;
    logic [3:0] w_tens;
    logic [3:0] w_ones;
    logic [3:0] w_digit;
    logic       w_blank_lz;
    logic [7:0] w_seg_lit;
    logic [7:0] w_an_lit;
    logic       w_blink_tc;

    // Pairs of digits share one snapshot byte; idx[0] picks tens over ones.
    always_comb begin
        case (r_idx[2:1])
            2'd0:    w_sel_byte = r_snap_cs;
            2'd1:    w_sel_byte = r_snap_sec;
            2'd2:    w_sel_byte = r_snap_min;
            default: w_sel_byte = r_snap_hour;
        endcase
    end

    bin2bcd99 u_bin2bcd99 (
        .i_bin  (w_sel_byte),
        .o_tens (w_tens),
        .o_ones (w_ones)
    );

    assign w_digit    = r_idx[0] ? w_tens : w_ones;
    assign w_blank_lz = (BLANK_LZ != 0) && (r_idx == 3'd7) && (w_tens == 4'd0);
    assign w_seg_lit  = w_blank_lz ? 8'hFF : {~DP_MASK[r_idx], seg_of(w_digit)};
    assign w_an_lit   = ~(8'h01 << r_idx);
    assign w_blink_tc = (r_blink_cnt == BCW'(BLINK_DIV - 1));

    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= 3'd0;
            r_phase     <= PH_GUARD;
            r_snap_cs   <= 8'd0;
            r_snap_sec  <= 8'd0;
            r_snap_min  <= 8'd0;
            r_snap_hour <= 8'd0;
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
            r_an        <= 8'hFF;
            r_seg       <= 8'hFF;
        end else begin
            if (r_idx == 3'd0 && r_phase == PH_GUARD) begin
                r_snap_cs   <= centisec;
                r_snap_sec  <= sec;
                r_snap_min  <= min;
                r_snap_hour <= hour;
            end

            if (r_phase == PH_LIT) begin
                r_idx   <= r_idx + 3'd1;
                r_phase <= PH_GUARD;
            end else begin
                r_phase <= PH_LIT;
            end

            if (!blink_en) begin
                r_blink_cnt <= '0;
                r_blink_off <= 1'b0;
            end else if (w_blink_tc) begin
                r_blink_cnt <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_blink_cnt <= r_blink_cnt + BCW'(1);
            end

            // Outputs follow the scan state by one cycle, so digit 0 lights
            // on the edge after the snapshot is taken.
            if (r_phase == PH_GUARD || (blink_en && r_blink_off)) begin
                r_an <= 8'hFF;
            end else begin
                r_an <= w_an_lit;
            end
            r_seg <= (r_phase == PH_GUARD) ? 8'hFF : w_seg_lit;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display: frame contents, snapshot timing,
// saturation, leading-zero blanking, blink and asynchronous reset.
module tb_stopwatch_display;

    logic       clk_1khz;
    logic       rst_n;
    logic [7:0] centisec;
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hour;
    logic       blink_en;
    logic [7:0] an;
    logic [7:0] seg;
    logic [7:0] an_lz0;
    logic [7:0] seg_lz0;

    int n_vec;
    int n_err;
    int n_edge;
    int cur_p;

    stopwatch_display #(.BLANK_LZ(1), .BLINK_DIV(4)) dut (
        .clk_1khz (clk_1khz),
        .rst_n    (rst_n),
        .centisec (centisec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .blink_en (blink_en),
        .an       (an),
        .seg      (seg)
    );

    stopwatch_display #(.BLANK_LZ(0), .BLINK_DIV(4)) dut_lz0 (
        .clk_1khz (clk_1khz),
        .rst_n    (rst_n),
        .centisec (centisec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .blink_en (blink_en),
        .an       (an_lz0),
        .seg      (seg_lz0)
    );

    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;

    // Expected anode pattern after the edge at frame position p.
    function automatic logic [7:0] exp_an(input int p);
        logic [7:0] one;
        one = 8'h01;
        if (p % 2 == 0) return 8'hFF;
        return ~(one << (p / 2));
    endfunction

    task automatic tick();
        @(posedge clk_1khz);
        #1;
        cur_p  = n_edge % 16;
        n_edge = n_edge + 1;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (cur_p != target && guard < 20);
        if (cur_p != target) begin
            n_vec++;
            n_err++;
            $display("FAIL run_to: position %0d required %0d", cur_p, target);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        blink_en = 1'b0;
        centisec = 8'd7;
        sec      = 8'd42;
        min      = 8'd5;
        hour     = 8'd3;
        tick();
        tick();
        n_vec++;
        if (an !== 8'hFF || seg !== 8'hFF) begin
            n_err++;
            $display("FAIL reset_out: an=%h seg=%h required FF FF", an, seg);
        end
    endtask

    task automatic test_frame();
        logic [7:0] tbl [8];
        logic [7:0] es;
        tbl = '{8'hF8, 8'hC0, 8'h24, 8'h99, 8'h12, 8'hC0, 8'h30, 8'hFF};
        rst_n  = 1'b1;
        n_edge = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            es = (k % 2 == 0) ? 8'hFF : tbl[k / 2];
            n_vec++;
            if (an !== exp_an(k) || seg !== es) begin
                n_err++;
                $display("FAIL frame_k%0d: an=%h seg=%h required %h %h", k, an, seg, exp_an(k), es);
            end
        end
    endtask

    task automatic test_tearing();
        centisec = 8'd0;
        sec      = 8'd41;
        min      = 8'd0;
        hour     = 8'd0;
        run_to(0);
        run_to(4);
        sec = 8'd42;
        run_to(5);
        n_vec++;
        if (an !== 8'hFB || seg !== 8'h79) begin
            n_err++;
            $display("FAIL tear_same_ones: an=%h seg=%h required FB 79", an, seg);
        end
        run_to(7);
        n_vec++;
        if (an !== 8'hF7 || seg !== 8'h99) begin
            n_err++;
            $display("FAIL tear_same_tens: an=%h seg=%h required F7 99", an, seg);
        end
        run_to(5);
        n_vec++;
        if (an !== 8'hFB || seg !== 8'h24) begin
            n_err++;
            $display("FAIL tear_next_ones: an=%h seg=%h required FB 24", an, seg);
        end
    endtask

    task automatic test_saturation();
        centisec = 8'd0;
        sec      = 8'd0;
        min      = 8'd150;
        hour     = 8'd200;
        run_to(0);
        run_to(9);
        n_vec++;
        if (seg !== 8'h10) begin
            n_err++;
            $display("FAIL sat_min_ones: seg=%h required 10", seg);
        end
        run_to(11);
        n_vec++;
        if (seg !== 8'h90) begin
            n_err++;
            $display("FAIL sat_min_tens: seg=%h required 90", seg);
        end
        run_to(13);
        n_vec++;
        if (seg !== 8'h10) begin
            n_err++;
            $display("FAIL sat_hour_ones: seg=%h required 10", seg);
        end
        run_to(15);
        n_vec++;
        if (an !== 8'h7F || seg !== 8'h90) begin
            n_err++;
            $display("FAIL sat_hour_tens: an=%h seg=%h required 7F 90", an, seg);
        end
    endtask

    task automatic test_leading_zero();
        min  = 8'd0;
        hour = 8'd4;
        run_to(0);
        run_to(13);
        n_vec++;
        if (seg_lz0 !== 8'h19) begin
            n_err++;
            $display("FAIL lz0_hour_ones: seg=%h required 19", seg_lz0);
        end
        run_to(15);
        n_vec++;
        if (an_lz0 !== 8'h7F || seg_lz0 !== 8'hC0) begin
            n_err++;
            $display("FAIL lz0_hour_tens: an=%h seg=%h required 7F C0", an_lz0, seg_lz0);
        end
        n_vec++;
        if (an !== 8'h7F || seg !== 8'hFF) begin
            n_err++;
            $display("FAIL lz1_blank: an=%h seg=%h required 7F FF", an, seg);
        end
    endtask

    task automatic test_blink();
        logic [7:0] ea;
        blink_en = 1'b1;
        for (int k = 0; k < 22; k++) begin
            tick();
            ea = ((k / 4) % 2 == 1) ? 8'hFF : exp_an(cur_p);
            n_vec++;
            if (an !== ea) begin
                n_err++;
                $display("FAIL blink_k%0d: an=%h required %h", k, an, ea);
            end
        end
        blink_en = 1'b0;
        tick();
        tick();
        n_vec++;
        if (an !== exp_an(cur_p)) begin
            n_err++;
            $display("FAIL blink_drop: an=%h required %h", an, exp_an(cur_p));
        end
    endtask

    task automatic test_reset_midframe();
        run_to(9);
        n_vec++;
        if (an !== 8'hEF) begin
            n_err++;
            $display("FAIL mid_pre: an=%h required EF", an);
        end
        #1;
        rst_n    = 1'b0;
        centisec = 8'd58;
        #1;
        n_vec++;
        if (an !== 8'hFF || seg !== 8'hFF) begin
            n_err++;
            $display("FAIL mid_async: an=%h seg=%h required FF FF", an, seg);
        end
        @(posedge clk_1khz);
        @(posedge clk_1khz);
        #3;
        rst_n  = 1'b1;
        n_edge = 0;
        tick();
        n_vec++;
        if (an !== 8'hFF) begin
            n_err++;
            $display("FAIL mid_first_edge: an=%h required FF", an);
        end
        tick();
        n_vec++;
        if (an !== 8'hFE || seg !== 8'h80) begin
            n_err++;
            $display("FAIL mid_capture: an=%h seg=%h required FE 80", an, seg);
        end
    endtask

    task automatic test_scan_1000();
        for (int k = 0; k < 1000; k++) begin
            centisec = 8'($urandom_range(0, 255));
            sec      = 8'($urandom_range(0, 255));
            min      = 8'($urandom_range(0, 255));
            hour     = 8'($urandom_range(0, 255));
            tick();
            n_vec++;
            if (an !== exp_an(cur_p)) begin
                n_err++;
                $display("FAIL scan_k%0d: an=%h required %h", k, an, exp_an(cur_p));
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        n_edge = 0;
        cur_p  = 0;
        test_reset();
        test_frame();
        test_tearing();
        test_saturation();
        test_leading_zero();
        test_blink();
        test_reset_midframe();
        test_scan_1000();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
